// File: rtl/matvec8_requant.sv
// rtl/matvec8_requant.sv - rounding requantizer (IN_W -> OUT_W) with saturation, element tagging and output FIFO
// Optional feature: define MATVEC8_REQUANT_RELU_EN to clamp negative results to 0 instead of -2^(OUT_W-1).
module matvec8_requant #(
  parameter int IN_W    = 28,
  parameter int OUT_W   = 14,
  parameter int DEPTH   = 8,
  parameter int VEC_LEN = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       shift,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [7:0]       sat_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (OUT_W - 1) - 1);

  logic                 in_fire, push, pop, empty, sat;
  logic signed [SW-1:0] ext, rnd, sum, shifted;
  logic [OUT_W-1:0]     clamped;

  logic                 st_valid, st_last, st_sat;
  logic [OUT_W-1:0]     st_data;
  logic [IW-1:0]        idx;

  logic [OUT_W:0]       mem [DEPTH];
  logic [OUT_W:0]       head;
  logic [AW:0]          wptr, rptr, count;

  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  // Stage occupancy is counted so that stage + FIFO never exceed DEPTH entries.
  assign in_ready = ({1'b0, count} + (AW + 2)'(st_valid)) < (AW + 2)'(DEPTH);
  assign in_fire  = in_valid && in_ready;
  assign push     = st_valid;
  assign pop      = out_valid && out_ready;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    ext     = {in_data[IN_W-1], in_data};
    rnd     = (shift == 4'd0) ? '0 : ({{(SW - 1){1'b0}}, 1'b1} << (shift - 4'd1));
    sum     = ext + rnd;
    shifted = sum >>> shift;
    clamped = shifted[OUT_W-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      clamped = MAX_V[OUT_W-1:0];
      sat     = 1'b1;
    end
`ifdef MATVEC8_REQUANT_RELU_EN
    else if (shifted[SW-1]) begin
      clamped = '0;
    end
`else
    else if (shifted < SW'(-(2 ** (OUT_W - 1)))) begin
      clamped = {1'b1, {(OUT_W - 1){1'b0}}};
      sat     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= 1'b0;
      st_data  <= '0;
      st_last  <= 1'b0;
      st_sat   <= 1'b0;
      idx      <= '0;
    end else begin
      st_valid <= in_fire;
      if (in_fire) begin
        st_data <= clamped;
        st_sat  <= sat;
        st_last <= (idx == IW'(VEC_LEN - 1));
        idx     <= (idx == IW'(VEC_LEN - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      sat_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && st_sat && sat_count != 8'hFF) sat_count <= sat_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {st_data, st_last};
  end

  // Head is masked while empty so stale storage never shows on the outputs.
  assign head      = mem[rptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[OUT_W:1];
  assign out_last  = !empty && head[0];
endmodule

// File: tb/tb_matvec8_requant.sv
// tb/tb_matvec8_requant.sv - directed and randomized-handshake bench for matvec8_requant
module tb_matvec8_requant;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  shift = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic        out_last;
  logic [7:0]  sat_count;

  int checks = 0;
  int errors = 0;
  int src[$];
  int exp_d[$];
  int got_d[$];
  bit got_l[$];
  int sent;
  int run_cycles;
  int exp_sat;

  always #5 clk = ~clk;

  matvec8_requant dut (
    .clk(clk), .reset_n(reset_n), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sat_count(sat_count)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int x, input int s);
    longint p = longint'(1) << s;
    longint v = longint'(x) + ((s == 0) ? 0 : p / 2);
    longint q = (v >= 0) ? v / p : -((-v + p - 1) / p);
    if (q > 8191) begin
      exp_sat++;
      return 8191;
    end
`ifdef MATVEC8_REQUANT_RELU_EN
    if (q < 0) return 0;
`else
    if (q < -8192) begin
      exp_sat++;
      return -8192;
    end
`endif
    return int'(q);
  endfunction

  task automatic clear();
    src.delete(); exp_d.delete(); got_d.delete(); got_l.delete();
    sent = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input bit rnd_hs, input int budget);
    bit hold = 1'b0;
    int hd = 0;
    bit hl = 1'b0;
    int cyc = 0;
    while ((sent < src.size() || got_d.size() < src.size()) && cyc < budget) begin
      in_valid = (sent < src.size()) && (!rnd_hs || $urandom_range(0, 1) == 1);
      if (sent < src.size()) in_data = 28'(src[sent]);
      else in_data = '0;
      out_ready = !rnd_hs || $urandom_range(0, 1) == 1;
      if (hold) begin
        chk("hold_data", $signed(out_data), hd);
        chk("hold_last", out_last, hl);
      end
      hold = out_valid && !out_ready;
      hd = $signed(out_data);
      hl = out_last;
      if (out_valid && out_ready) begin
        got_d.push_back($signed(out_data));
        got_l.push_back(out_last);
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    run_cycles = cyc;
    chk("run_complete", got_d.size(), src.size());
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      chk({tag, "_data"}, got_d[i], exp_d[i]);
      chk({tag, "_last"}, got_l[i], (i % 8) == 7);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_count", sat_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // minimum latency: accepted at edge N, visible after edge N+1
    shift = 4'd4; in_valid = 1'b1; in_data = 28'd16;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_edge_n", out_valid, 0);
    @(negedge clk);
    chk("lat_edge_n1", out_valid, 1);
    chk("lat_data", $signed(out_data), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_popped", out_valid, 0);
    do_reset();

    // rounding, shift=4, full throughput
    clear(); shift = 4'd4;
    src = '{16100, 5180, -13810, -666, 0, 0, 0, 0};
    exp_d = '{1006, 324, -863, -42, 0, 0, 0, 0};
    run(1'b0, 50);
    chk("t1_cycles", run_cycles, 10);
    compare("t1");
    chk("t1_sat", sat_count, 0);

    // saturation, shift=0
    do_reset(); clear(); shift = 4'd0;
    src = '{16100, -13810, 683};
`ifdef MATVEC8_REQUANT_RELU_EN
    exp_d = '{8191, 0, 683};
`else
    exp_d = '{8191, -8192, 683};
`endif
    run(1'b0, 50);
    compare("t2");
`ifdef MATVEC8_REQUANT_RELU_EN
    chk("t2_sat", sat_count, 1);
`else
    chk("t2_sat", sat_count, 2);
`endif

    // backpressure, capacity and recovery
    do_reset(); clear(); shift = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      src.push_back(i);
      exp_d.push_back(i);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data = 28'(src[sent]);
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_accepted", sent, 8);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_full_valid", out_valid, 1);
    out_ready = 1'b1;
    got_d.push_back($signed(out_data));
    got_l.push_back(out_last);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t3_recover", in_ready, 1);
    run(1'b0, 100);
    compare("t3");

    // random handshakes against the reference model
    do_reset(); clear(); shift = 4'd5; exp_sat = 0;
    for (int i = 0; i < 1000; i++) begin
      int v;
      v = $urandom;
      v = v >>> $urandom_range(4, 20);
      src.push_back(v);
      exp_d.push_back(model(v, 5));
    end
    run(1'b1, 20000);
    compare("t4");
    chk("t4_sat", sat_count, (exp_sat > 255) ? 255 : exp_sat);

    // asynchronous reset with buffered data
    do_reset(); clear(); shift = 4'd0; out_ready = 1'b0;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      in_valid = 1'b1;
      in_data = 28'd20000;
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_accepted", sent, 5);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("t5_sat_before", sat_count, 5);
    chk("t5_buffered", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sat", sat_count, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_data", $signed(out_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear();
    for (int i = 1; i <= 8; i++) begin
      src.push_back(i);
      exp_d.push_back(i);
    end
    run(1'b0, 50);
    compare("t5");

    // sticky saturation counter
    do_reset(); clear(); shift = 4'd0;
    for (int i = 0; i < 300; i++) begin
      src.push_back(20000);
      exp_d.push_back(8191);
    end
    run(1'b0, 1000);
    compare("t6");
    chk("t6_sat", sat_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matvec8_requant.md
# matvec8_requant

Downstream stage for `matvec8_part3`. It consumes the 28-bit signed dot-product stream, requantizes each element to 14 bits with a rounding arithmetic right shift and saturation, and buffers the results in a small FIFO. The output stream is 14-bit, so it can feed directly into the vector input of another `matvec8_part3`, which lets layers be chained. It also tags the last element of each 8-element vector and counts saturation events.

## Interface

**Parameters**
- `IN_W`, 28: input element width (signed).
- `OUT_W`, 14: output element width (signed).
- `DEPTH`, 8: FIFO depth; must be a power of 2, ≥ 2.
- `VEC_LEN`, 8: elements per vector; used for `out_last`.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `shift` in 4: right-shift amount, 0–15. Changed only when the block is empty.
- `in_valid` in 1: upstream data valid.
- `in_ready` out 1: block can accept data.
- `in_data` in `IN_W`: signed dot product from `matvec8_part3` `output_data`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out `OUT_W`: requantized element.
- `out_last` out 1: head element is index `VEC_LEN`-1 of its vector.
- `sat_count` out 8: number of saturated elements, sticky at 255.

## Operation

- **Transfer:** a transfer occurs on any rising edge where valid and ready are both high, on either port. Data is never dropped or duplicated.
- **Stage 1 (registered):** on input transfer, capture `r = (in_data + rnd) >>> shift`, where `rnd = (shift==0) ? 0 : 1<<(shift-1)`.
  - The add is computed at `IN_W+1` bits, so there is no overflow.
  - Result is round-half-up toward +inf (e.g. -2.5 → -2).
- **Saturation:** clamp `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8192, 8191].
  - Sets flag `sat` when clamping changes the value.
  - The flag and the clamped value are captured alongside each other.
- **Element counter:** `idx`, 0..`VEC_LEN`-1.
  - Increments on each input transfer and wraps from `VEC_LEN`-1 to 0.
  - `last = (idx==VEC_LEN-1)` is captured with the element.
- **Stage 2 (FIFO):** the stage-1 entry `{data, last}` is written into the FIFO on the next edge when the stage is valid.
  - The FIFO is `DEPTH` entries with read/write pointers `log2(DEPTH)+1` bits wide; the MSB distinguishes full from empty.
- **`sat_count`:** increments by 1 when a saturated element is written to the FIFO. It holds at 255.
- **Outputs:** `out_valid = !empty`. `out_data` and `out_last` come from the FIFO head and are held stable while `out_valid && !out_ready`.
- **`in_ready`:** `(fifo_count + stage_valid) < DEPTH`.
  - Computed combinationally from registered state only; it never depends on `out_ready` or `in_valid`.
- **Simultaneous events:**
  - FIFO push and pop in the same cycle: count unchanged, data order preserved.
  - When full, a same-cycle pop does not raise `in_ready` until the next cycle.
- **Reset** (asynchronous, any time, including mid-vector):
  - Pointers, `idx`, `stage_valid` and `sat_count` clear to 0.
  - `out_valid=0`, `out_last=0`, `out_data=0`.
  - `in_ready` is 1 after reset.
  - Partial vectors are discarded.

## Timing

- **Minimum latency:** input transfer at edge N → `out_valid` high after edge N+1.
- **Throughput:** one element per cycle when `out_ready` is held high.
- **Capacity:** with `out_ready=0`, the block accepts exactly `DEPTH` elements (stage plus FIFO combined) before `in_ready` falls.
- **Recovery:** after one pop from full, `in_ready` rises the following cycle.
- **`shift`:** sampled at stage-1 capture.

## Configuration

- **`MATVEC8_REQUANT_RELU_EN` defined:**
  - The lower clamp bound is 0, so negative results output 0.
  - Clamping a negative value to 0 does NOT count as saturation; only values > 8191 count.
- **Undefined:** signed saturation to [-8192, 8191], with both bounds counting as saturation.

## Test plan

1. **Rounding and saturation** (`shift=4`; `RELU` undefined).
   - Stream 16100, 5180, -13810, -666, then 4 zeros, with `out_ready=1`.
   - Expect 1006, 324, -863, -42, 0, 0, 0, 0.
   - `out_last` high only on the 8th output; `sat_count=0`.
2. **Saturation** (`shift=0`).
   - Send 16100, -13810, 683.
   - Expect 8191, -8192, 683; `sat_count=2`.
   - With `MATVEC8_REQUANT_RELU_EN`: expect 8191, 0, 683; `sat_count=1`.
3. **Backpressure** (`out_ready=0`, continuous `in_valid`, 16 inputs 1..16, `shift=0`).
   - Exactly 8 are accepted, then `in_ready=0`.
   - Raise `out_ready`: 1..16 emerge in order with no gaps or duplicates.
   - `out_last` on values 8 and 16.
4. **Random handshakes:** 1000 elements with random `in_valid`/`out_ready` toggling each cycle.
   - Output matches the reference model exactly.
   - Outputs are stable whenever `out_valid && !out_ready`.
5. **Reset mid-operation:** assert `reset_n=0` after 5 accepted inputs with 3 buffered.
   - Immediately: `out_valid=0`, `sat_count=0`.
   - After release: 8 new inputs give `out_last` on the 8th (counter restarted).
6. **Counter sticky:** 300 saturating inputs with `shift=0` and value 20000.
   - `sat_count` ends at 255; all outputs are 8191.
